occupancy_grid_controller: RTL

OCCUPANCY_GRID_CONTROLLER -- requirements
Module: occupancy_grid_controller

---
 rtl/occupancy_pkg.sv | 14 +
 rtl/occupancy_grid_controller_saturate.sv | 46 ++++
 rtl/occupancy_grid_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/occupancy_pkg.sv
// Shared types and default tuning values for the occupancy grid controller.
package occupancy_pkg;

    localparam int CELL_WIDTH_DEFAULT = 8;
    localparam int HIT_INC_DEFAULT    = 4;
    localparam int MISS_DEC_DEFAULT   = 1;
    localparam int CELL_MAX_DEFAULT   = 127;
    localparam int CELL_MIN_DEFAULT   = -128;
    localparam int CELL_INIT_DEFAULT  = 0;

    // One log-odds grid cell at the default width.
    typedef logic signed [CELL_WIDTH_DEFAULT-1:0] cell_t;

endpackage

// File: rtl/occupancy_grid_controller_saturate.sv
// Combinational log-odds update: adds the hit increment or subtracts the miss
// decrement with two guard bits, then clamps into [CELL_MIN, CELL_MAX].
module log_odds_saturate
    import occupancy_pkg::*;
#(
    parameter int CELL_WIDTH = CELL_WIDTH_DEFAULT,
    parameter int HIT_INC    = HIT_INC_DEFAULT,
    parameter int MISS_DEC   = MISS_DEC_DEFAULT,
    parameter int CELL_MAX   = CELL_MAX_DEFAULT,
    parameter int CELL_MIN   = CELL_MIN_DEFAULT
) (
    input  logic signed [CELL_WIDTH-1:0] cell_value,
    input  logic                         hit,
    output logic signed [CELL_WIDTH-1:0] new_value
);

    localparam int WIDE_W = CELL_WIDTH + 2;
    localparam logic signed [WIDE_W-1:0] INC_W = WIDE_W'(HIT_INC);
    localparam logic signed [WIDE_W-1:0] DEC_W = WIDE_W'(MISS_DEC);
    localparam logic signed [WIDE_W-1:0] MAX_W = WIDE_W'(CELL_MAX);
    localparam logic signed [WIDE_W-1:0] MIN_W = WIDE_W'(CELL_MIN);

    // Clamp a widened sum back into the legal cell range.
    function automatic logic signed [CELL_WIDTH-1:0] saturate(input logic signed [WIDE_W-1:0] value);
        logic signed [CELL_WIDTH-1:0] result;
        if (value > MAX_W) begin
            result = CELL_WIDTH'(MAX_W);
        end else if (value < MIN_W) begin
            result = CELL_WIDTH'(MIN_W);
        end else begin
            result = value[CELL_WIDTH-1:0];
        end
        return result;
    endfunction

    logic signed [WIDE_W-1:0] cell_wide;
    logic signed [WIDE_W-1:0] sum_wide;

    // Sign-extend, apply the hit/miss step, then saturate.
    always_comb begin
        cell_wide = WIDE_W'(cell_value);
        sum_wide  = hit ? (cell_wide + INC_W) : (cell_wide - DEC_W);
        new_value = saturate(sum_wide);
    end

endmodule

// File: rtl/occupancy_grid_controller.sv
// Occupancy grid controller: serialises full-grid clears, read-modify-write
// log-odds updates and host reads onto a single-port grid RAM with one cycle
// of read latency.
module occupancy_grid_controller
    import occupancy_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int CELL_WIDTH = CELL_WIDTH_DEFAULT,
    parameter int HIT_INC    = HIT_INC_DEFAULT,
    parameter int MISS_DEC   = MISS_DEC_DEFAULT,
    parameter int CELL_MAX   = CELL_MAX_DEFAULT,
    parameter int CELL_MIN   = CELL_MIN_DEFAULT,
    parameter int CELL_INIT  = CELL_INIT_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         zero_occupancy_grid,
    output logic                         busy,
    input  logic                         update_valid,
    input  logic [ADDR_WIDTH-1:0]        update_address,
    input  logic                         update_hit,
    output logic                         update_ready,
    input  logic                         read_request,
    input  logic [ADDR_WIDTH-1:0]        read_address,
    output logic                         read_ready,
    output logic                         read_valid,
    output logic signed [CELL_WIDTH-1:0] read_data,
    output logic [ADDR_WIDTH-1:0]        mem_address,
    output logic                         mem_write_enable,
    output logic signed [CELL_WIDTH-1:0] mem_write_data,
    input  logic signed [CELL_WIDTH-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        UPD_READ,
        UPD_WRITE,
        HOST_READ,
        HOST_DATA
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]        LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic signed [CELL_WIDTH-1:0] INIT_V    = CELL_WIDTH'(CELL_INIT);

    state_t                         state;
    state_t                         state_next;
    logic [ADDR_WIDTH-1:0]          clear_count;
    logic [ADDR_WIDTH-1:0]          upd_addr;
    logic                           upd_hit;
    logic [ADDR_WIDTH-1:0]          rd_addr;
    logic signed [CELL_WIDTH-1:0]   sat_value;

    log_odds_saturate #(
        .CELL_WIDTH (CELL_WIDTH),
        .HIT_INC    (HIT_INC),
        .MISS_DEC   (MISS_DEC),
        .CELL_MAX   (CELL_MAX),
        .CELL_MIN   (CELL_MIN)
    ) u_saturate (
        .cell_value (mem_read_data),
        .hit        (upd_hit),
        .new_value  (sat_value)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, handshakes and RAM port drive; IDLE priority is clear, update, read.
    always_comb begin
        state_next       = state;
        busy             = (state != IDLE);
        update_ready     = 1'b0;
        read_ready       = 1'b0;
        mem_address      = '0;
        mem_write_enable = 1'b0;
        mem_write_data   = '0;
        case (state)
            IDLE: begin
                update_ready = !reset && !zero_occupancy_grid;
                read_ready   = !reset && !zero_occupancy_grid && !update_valid;
                if (zero_occupancy_grid) begin
                    state_next = CLEAR;
                end else if (update_valid) begin
                    state_next = UPD_READ;
                end else if (read_request) begin
                    state_next = HOST_READ;
                end
            end
            CLEAR: begin
                mem_address      = clear_count;
                mem_write_enable = 1'b1;
                mem_write_data   = INIT_V;
                if (!zero_occupancy_grid && clear_count == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            UPD_READ: begin
                mem_address = upd_addr;
                state_next  = UPD_WRITE;
            end
            UPD_WRITE: begin
                mem_address      = upd_addr;
                mem_write_enable = 1'b1;
                mem_write_data   = sat_value;
                state_next       = IDLE;
            end
            HOST_READ: begin
                mem_address = rd_addr;
                state_next  = HOST_DATA;
            end
            HOST_DATA: begin
                mem_address = rd_addr;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clear address counter: starts at 0 on a clear request, restarts if re-requested mid-clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clear_count <= '0;
        end else if (state == IDLE && zero_occupancy_grid) begin
            clear_count <= '0;
        end else if (state == CLEAR) begin
            clear_count <= zero_occupancy_grid ? '0 : clear_count + 1'b1;
        end
    end

    // Host read return path: capture RAM data and strobe read_valid once; data holds until the next read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            read_valid <= (state == HOST_DATA);
            if (state == HOST_DATA) begin
                read_data <= mem_read_data;
            end
        end
    end

    // Latch the request operands on acceptance; these are pure data and need no reset.
    always_ff @(posedge clock) begin
        if (update_ready && update_valid) begin
            upd_addr <= update_address;
            upd_hit  <= update_hit;
        end
        if (read_ready && read_request) begin
            rd_addr <= read_address;
        end
    end

endmodule
